player_controller: RTL
======================

# player_controller

Per-player fighter state machine feeding the game controller: one instance per player converts four button levels and an incoming hit pulse into a movement/attack state, screen position and remaining health. Runs on the 60 Hz frame clock. Is gated by the game controller's `game_state`. Its `player_state`/`player_health` outputs drive the game controller's fight-resolution inputs, and `attack_active` drives the opponent instance's hit detection.

## Interface
- `START_X`, 100: position loaded on countdown entry and at reset
- `SPEED`, 2: pixels moved per frame while walking
- `X_MIN`, 0: left position limit
- `X_MAX`, 600: right position limit
- `WINDUP_FRAMES`, 6: attack wind-up length in frames, 1..31
- `ACTIVE_FRAMES`, 4: attack hitbox length in frames, 1..31
- `RECOVER_FRAMES`, 8: attack recovery length in frames, 1..31
- `HITSTUN_FRAMES`, 15: hit-stun length in frames, 1..31
- `MAX_HEALTH`, 3: starting health, 1..7

Ports:
- `clk`  in  1  clock; 60 Hz frame clock
- `reset`  in  1  reset; asynchronous, active-high
- `game_state`  in  3  game controller state: 0 idle, 1 countdown, 2 fight, 3/4/5 result
- `btn_left`  in  1  move-left level, synchronised, active-high
- `btn_right`  in  1  move-right level, synchronised, active-high
- `btn_attack`  in  1  attack level, synchronised, active-high
- `btn_block`  in  1  block level, synchronised, active-high
- `hit_in`  in  1  opponent hitbox overlaps this player this frame
- `player_state`  out  3  current FSM state encoding
- `player_health`  out  3  remaining health, 0 = defeated
- `position`  out  10  horizontal position
- `attack_active`  out  1  high while in ATTACK

## Operation
- **State encoding:**
  - 0 IDLE, 1 MOVE_L, 2 MOVE_R, 3 WINDUP, 4 ATTACK, 5 RECOVER, 6 BLOCK, 7 HITSTUN.
- **Reset values:**
  - state IDLE, health MAX_HEALTH, position START_X, attack_active 0.
  - Internal 5-bit frame counter cleared.
- **Gating by `game_state`:**
  - `game_state`≠2: state forced IDLE, frame counter cleared, buttons and `hit_in` ignored.
  - `game_state`==1: also reloads health to MAX_HEALTH and position to START_X every cycle.
  - `game_state` 0, 3, 4, 5: health and position hold.
- **Free states (IDLE, MOVE_L, MOVE_R, BLOCK):** next state chosen by priority:
  - attack → WINDUP
  - else block → BLOCK
  - else exactly one of left/right → MOVE_L / MOVE_R
  - else (none, or left and right together) → IDLE
- **Timed states (WINDUP, ATTACK, RECOVER, HITSTUN):**
  - Entry clears the frame counter.
  - Counter increments each cycle. The state is left when the counter equals its length−1, so each timed state lasts exactly its parameter in cycles.
  - Chain: WINDUP → ATTACK → RECOVER → IDLE, and HITSTUN → IDLE.
  - Buttons are ignored during timed states.
- **Movement:**
  - In MOVE_L, position decreases by SPEED per cycle, saturating at X_MIN.
  - In MOVE_R, position increases by SPEED per cycle, saturating at X_MAX.
  - Arithmetic is done at 11 bits before clamping, so there is no wrap.
- **Hits (`game_state`==2, `hit_in`=1):**
  - In BLOCK: no damage, stay BLOCK.
  - In HITSTUN: ignored (invulnerable).
  - Any other state:
    - health decrements, saturating at 0;
    - next state is HITSTUN with the frame counter cleared;
    - a pending attack is cancelled.
  - A hit has priority over button decoding and over a timed-state transition in the same cycle.
- **Defeat:**
  - When health is 0 the state is forced IDLE.
  - All buttons and hits are ignored until reload on countdown.
- **Output:** `attack_active` = (state==ATTACK).

## Timing
- All outputs are registered and update on the `clk` edge after the input is sampled, i.e. 1-cycle latency.
- Attack pressed and sampled at edge n:
  - WINDUP over n+1 .. n+WINDUP_FRAMES;
  - ATTACK for ACTIVE_FRAMES cycles;
  - RECOVER for RECOVER_FRAMES cycles;
  - IDLE, if no button is held.
- A hit sampled at edge n:
  - health decreases at n+1;
  - HITSTUN for HITSTUN_FRAMES cycles;
  - then IDLE.
- Reset asserted mid-state: all outputs return immediately (asynchronously) to their reset values.

## Test plan
- **Reset, countdown reload:** reset, then `game_state`=1 for 3 cycles → health 3, position 100, state 0; with `btn_right` held, position stays 100.
- **Walk to limit:** `game_state`=2, `btn_right` held 400 cycles → state 2, position increments by 2 to 600 and holds. Then left+right together → state 0.
- **Attack timeline:** `btn_attack` pulse for 1 cycle → state 3 for 6 cycles, 4 for 4 cycles (`attack_active`=1 only then), 5 for 8 cycles, then 0.
- **Hit during windup:** `hit_in` pulse in the 3rd WINDUP cycle → health 3→2, state 7 for 15 cycles, then 0, with no ATTACK state reached.
- **Block and invulnerability:**
  - `btn_block` held plus `hit_in` → health unchanged, state 6.
  - A second `hit_in` during HITSTUN → health unchanged.
- **Defeat and freeze:**
  - Three separated hits → health 0, state 0; further inputs ignored.
  - `game_state`=4 → outputs hold.
  - `game_state`=1 → health reloads to 3.

Source files
------------

// File: rtl/player_controller.sv
// Per-player fighter FSM: buttons and incoming hits become a movement/attack
// state, a clamped screen position and remaining health, gated by game_state.
module player_controller #(
  parameter int START_X        = 100,
  parameter int SPEED          = 2,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 600,
  parameter int WINDUP_FRAMES  = 6,
  parameter int ACTIVE_FRAMES  = 4,
  parameter int RECOVER_FRAMES = 8,
  parameter int HITSTUN_FRAMES = 15,
  parameter int MAX_HEALTH     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] game_state,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       btn_block,
  input  logic       hit_in,
  output logic [2:0] player_state,
  output logic [2:0] player_health,
  output logic [9:0] position,
  output logic       attack_active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_L  = 3'd1,
    MOVE_R  = 3'd2,
    WINDUP  = 3'd3,
    ATTACK  = 3'd4,
    RECOVER = 3'd5,
    BLOCK   = 3'd6,
    HITSTUN = 3'd7
  } state_t;

  state_t      r_state, w_state_n;
  logic [4:0]  r_cnt, w_cnt_n;
  logic [2:0]  r_health, w_health_n;
  logic [9:0]  r_pos, w_pos_n;
  logic [10:0] w_pos_l, w_pos_r;
  state_t      w_free_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_health <= 3'(MAX_HEALTH);
      r_pos    <= 10'(START_X);
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_health <= w_health_n;
      r_pos    <= w_pos_n;
    end
  end

  // Movement is computed at 11 bits so clamping never sees a wrapped value.
  always_comb begin
    w_pos_l = {1'b0, r_pos} - 11'(SPEED);
    w_pos_r = {1'b0, r_pos} + 11'(SPEED);
    if ({1'b0, r_pos} < 11'(X_MIN + SPEED)) w_pos_l = 11'(X_MIN);
    if (w_pos_r > 11'(X_MAX))               w_pos_r = 11'(X_MAX);
  end

  always_comb begin
    w_free_n = IDLE;
    if (btn_attack)                  w_free_n = WINDUP;
    else if (btn_block)              w_free_n = BLOCK;
    else if (btn_left && !btn_right) w_free_n = MOVE_L;
    else if (btn_right && !btn_left) w_free_n = MOVE_R;
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_health_n = r_health;
    w_pos_n    = r_pos;
    if (game_state != 3'd2) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
      if (game_state == 3'd1) begin
        w_health_n = 3'(MAX_HEALTH);
        w_pos_n    = 10'(START_X);
      end
    end else if (r_health == 3'd0) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
    end else begin
      if (r_state == MOVE_L) w_pos_n = w_pos_l[9:0];
      if (r_state == MOVE_R) w_pos_n = w_pos_r[9:0];
      if (hit_in && r_state != BLOCK && r_state != HITSTUN) begin
        w_health_n = r_health - 3'd1;
        w_state_n  = HITSTUN;
        w_cnt_n    = '0;
      end else begin
        w_cnt_n = r_cnt + 5'd1;
        unique case (r_state)
          WINDUP:  if (r_cnt == 5'(WINDUP_FRAMES - 1))  begin w_state_n = ATTACK;  w_cnt_n = '0; end
          ATTACK:  if (r_cnt == 5'(ACTIVE_FRAMES - 1))  begin w_state_n = RECOVER; w_cnt_n = '0; end
          RECOVER: if (r_cnt == 5'(RECOVER_FRAMES - 1)) begin w_state_n = IDLE;    w_cnt_n = '0; end
          HITSTUN: if (r_cnt == 5'(HITSTUN_FRAMES - 1)) begin w_state_n = IDLE;    w_cnt_n = '0; end
          default: begin
            w_cnt_n   = '0;
            w_state_n = (r_state == BLOCK && hit_in) ? BLOCK : w_free_n;
          end
        endcase
      end
    end
  end

  assign player_state  = r_state;
  assign player_health = r_health;
  assign position      = r_pos;
  assign attack_active = (r_state == ATTACK);

endmodule
